mac_array_2x2_seq: RTL and testbench

Sequencer for the 2x2 MAC array. It computes C = A·B, where A is 2×K and B is K×2 with K = 1..MAX_K. It accepts one operand beat per step k, drives the array's clear, enable and operand ports, then captures the four accumulators and presents them on a valid/ready result port. It sits between the operand-fetch logic and `mac_array_2x2`, and owns all `clear_all` and `enable` traffic to the array.

---
 rtl/mac_array_2x2_seq.sv | 168 ++++++++++++++++
 tb/tb_mac_array_2x2_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_2x2_seq.sv
// -----------------------------------------------------------------------------
// mac_array_2x2_seq
//
// Sequencer for the 2x2 MAC array computing C = A*B, where A is 2xK and B is
// Kx2 with K = 1..MAX_K. It takes one operand beat per step k and fans it out
// to the array operand ports. It owns all clear_all/enable traffic to the
// array. At the end of a job it captures the four accumulators and offers them
// on a valid/ready result port.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start, k_len        job request (sampled in IDLE only), depth latched on start
//   busy, done          not-idle flag, one-cycle pulse after result handshake
//   op_valid/op_ready   operand beat handshake; op_a0/op_a1/op_b0/op_b1 data
//   res_valid/res_ready result handshake; res_c00..res_c11 captured C[i][j]
//   mac_enable          array enable (accumulate a*b)
//   mac_clear_all       array synchronous clear
//   mac_a_*/mac_b_*     array operands, zero outside FEED
//   mac_acc_*           array accumulators
// -----------------------------------------------------------------------------
module mac_array_2x2_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int MAX_K      = 16,
  parameter int KW         = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_a0,
  input  logic [DATA_WIDTH-1:0] op_a1,
  input  logic [DATA_WIDTH-1:0] op_b0,
  input  logic [DATA_WIDTH-1:0] op_b1,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_c00,
  output logic [ACC_WIDTH-1:0]  res_c01,
  output logic [ACC_WIDTH-1:0]  res_c10,
  output logic [ACC_WIDTH-1:0]  res_c11,
  output logic                  mac_enable,
  output logic                  mac_clear_all,
  output logic [DATA_WIDTH-1:0] mac_a_00,
  output logic [DATA_WIDTH-1:0] mac_a_01,
  output logic [DATA_WIDTH-1:0] mac_a_10,
  output logic [DATA_WIDTH-1:0] mac_a_11,
  output logic [DATA_WIDTH-1:0] mac_b_00,
  output logic [DATA_WIDTH-1:0] mac_b_01,
  output logic [DATA_WIDTH-1:0] mac_b_10,
  output logic [DATA_WIDTH-1:0] mac_b_11,
  input  logic [ACC_WIDTH-1:0]  mac_acc_00,
  input  logic [ACC_WIDTH-1:0]  mac_acc_01,
  input  logic [ACC_WIDTH-1:0]  mac_acc_10,
  input  logic [ACC_WIDTH-1:0]  mac_acc_11
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  localparam logic [KW-1:0] MAX_K_W = KW'(MAX_K);

  state_t        state, state_nx;
  logic [KW-1:0] remaining;
  logic [KW-1:0] k_clamped;
  logic          in_feed;
  logic          beat_take;
  logic          res_take;

  assign k_clamped = (k_len > MAX_K_W) ? MAX_K_W : k_len;
  assign in_feed   = (state == FEED);
  assign beat_take = in_feed && op_valid;
  assign res_take  = (state == RESULT) && res_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = CLEAR;
      CLEAR:  state_nx = (remaining == '0) ? DRAIN : FEED;
      // remaining <= 1 rather than == 1 so a corrupted count can never
      // strand the FSM in FEED.
      FEED:   if (beat_take && (remaining <= KW'(1))) state_nx = DRAIN;
      DRAIN:  state_nx = RESULT;
      RESULT: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Beat counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
    end else if ((state == IDLE) && start) begin
      remaining <= k_clamped;
    end else if (beat_take) begin
      remaining <= remaining - KW'(1);
    end
  end

  // Result capture on the DRAIN exit edge; the last accumulate is visible
  // by then because the array updates on the edge that enters DRAIN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_c00 <= '0;
      res_c01 <= '0;
      res_c10 <= '0;
      res_c11 <= '0;
    end else if (state == DRAIN) begin
      res_c00 <= mac_acc_00;
      res_c01 <= mac_acc_01;
      res_c10 <= mac_acc_10;
      res_c11 <= mac_acc_11;
    end
  end

  // done is high in the cycle after the handshake edge, alongside IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= res_take;
  end

  // Status and array control
  always_comb begin
    busy          = (state != IDLE);
    op_ready      = in_feed;
    res_valid     = (state == RESULT);
    mac_clear_all = (state == CLEAR);
    mac_enable    = beat_take;
  end

  // Operand fan-out: row operands to both columns, column operands to both rows.
  always_comb begin
    mac_a_00 = '0;
    mac_a_01 = '0;
    mac_a_10 = '0;
    mac_a_11 = '0;
    mac_b_00 = '0;
    mac_b_01 = '0;
    mac_b_10 = '0;
    mac_b_11 = '0;
    if (in_feed) begin
      mac_a_00 = op_a0;
      mac_a_01 = op_a0;
      mac_a_10 = op_a1;
      mac_a_11 = op_a1;
      mac_b_00 = op_b0;
      mac_b_10 = op_b0;
      mac_b_01 = op_b1;
      mac_b_11 = op_b1;
    end
  end

endmodule

// File: tb/tb_mac_array_2x2_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_array_2x2_seq
//
// Directed bench for mac_array_2x2_seq. It includes a behavioural model of the
// 2x2 MAC array that the sequencer drives. Expected results are hand-computed
// constants.
// -----------------------------------------------------------------------------
module tb_mac_array_2x2_seq;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int KW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_a0 = '0, op_a1 = '0, op_b0 = '0, op_b1 = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [AW-1:0] res_c00, res_c01, res_c10, res_c11;
  logic          mac_enable, mac_clear_all;
  logic [DW-1:0] mac_a_00, mac_a_01, mac_a_10, mac_a_11;
  logic [DW-1:0] mac_b_00, mac_b_01, mac_b_10, mac_b_11;
  logic [AW-1:0] acc00 = '0, acc01 = '0, acc10 = '0, acc11 = '0;

  int tests  = 0;
  int failed = 0;
  int cyc = 0, en_cnt = 0, clr_cnt = 0, rdy_cnt = 0, both_cnt = 0;

  logic [DW-1:0] ba0 [20];
  logic [DW-1:0] ba1 [20];
  logic [DW-1:0] bb0 [20];
  logic [DW-1:0] bb1 [20];

  mac_array_2x2_seq #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(16), .KW(KW)) dut (
    .clock(clock), .reset(reset), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a0(op_a0), .op_a1(op_a1), .op_b0(op_b0), .op_b1(op_b1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c00(res_c00), .res_c01(res_c01), .res_c10(res_c10), .res_c11(res_c11),
    .mac_enable(mac_enable), .mac_clear_all(mac_clear_all),
    .mac_a_00(mac_a_00), .mac_a_01(mac_a_01), .mac_a_10(mac_a_10), .mac_a_11(mac_a_11),
    .mac_b_00(mac_b_00), .mac_b_01(mac_b_01), .mac_b_10(mac_b_10), .mac_b_11(mac_b_11),
    .mac_acc_00(acc00), .mac_acc_01(acc01), .mac_acc_10(acc10), .mac_acc_11(acc11)
  );

  always #5 clock = ~clock;

  // Array model: clear has priority, not affected by reset.
  always @(posedge clock) begin
    if (mac_clear_all) begin
      acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
    end else if (mac_enable) begin
      acc00 <= acc00 + AW'(mac_a_00 * mac_b_00);
      acc01 <= acc01 + AW'(mac_a_01 * mac_b_01);
      acc10 <= acc10 + AW'(mac_a_10 * mac_b_10);
      acc11 <= acc11 + AW'(mac_a_11 * mac_b_11);
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mac_enable)                  en_cnt   <= en_cnt + 1;
    if (mac_clear_all)               clr_cnt  <= clr_cnt + 1;
    if (op_ready)                    rdy_cnt  <= rdy_cnt + 1;
    if (mac_enable && mac_clear_all) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int i = 0; i < 20; i++) begin
      ba0[i] = v; ba1[i] = v; bb0[i] = v; bb1[i] = v;
    end
  endtask

  task automatic set_beat(input int i);
    op_a0 = ba0[i]; op_a1 = ba1[i]; op_b0 = bb0[i]; op_b1 = bb1[i];
  endtask

  task automatic load_basic();
    ba0[0] = 1; ba1[0] = 3; bb0[0] = 5; bb1[0] = 6;
    ba0[1] = 2; ba1[1] = 4; bb0[1] = 7; bb1[1] = 8;
  endtask

  // Called #1 after a clock edge; start is sampled on the next edge.
  task automatic run_job(input string tag, input int k_in, input int nbeats,
                         input int gap, input int hold, input bit poke,
                         input logic [AW-1:0] e00, input logic [AW-1:0] e01,
                         input logic [AW-1:0] e10, input logic [AW-1:0] e11,
                         input int exp_lat, input int exp_beats);
    int c0, taken, gap_left, guard, en0, clr0, rdy0;
    bit take, stable;
    en0 = en_cnt; clr0 = clr_cnt; rdy0 = rdy_cnt;
    start = 1'b1;
    k_len = KW'(k_in);
    set_beat(0);
    op_valid = (nbeats > 0);
    @(posedge clock); #1;
    start = 1'b0;
    c0 = cyc;
    taken = 0; gap_left = 0; guard = 0;
    while (!res_valid && guard < 300) begin
      take = op_valid && op_ready;
      @(posedge clock); #1;
      guard++;
      start = poke && (guard == 2);
      if (poke) k_len = KW'(3);
      if (take) begin
        taken++;
        gap_left = gap;
      end
      if (gap_left > 0) begin
        op_valid = 1'b0;
        gap_left--;
      end else begin
        op_valid = (taken < nbeats);
        if (taken < nbeats) set_beat(taken);
      end
    end
    start = 1'b0;
    op_valid = 1'b0;
    check({tag, ".res_valid_seen"}, res_valid, 1);
    if (exp_lat >= 0) check({tag, ".latency"}, cyc - c0, exp_lat);
    check({tag, ".beats"}, taken, exp_beats);
    check({tag, ".enables"}, en_cnt - en0, exp_beats);
    check({tag, ".clears"}, clr_cnt - clr0, 1);
    if (exp_beats == 0) check({tag, ".op_ready_cycles"}, rdy_cnt - rdy0, 0);
    check({tag, ".c00"}, res_c00, e00);
    check({tag, ".c01"}, res_c01, e01);
    check({tag, ".c10"}, res_c10, e10);
    check({tag, ".c11"}, res_c11, e11);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (res_valid !== 1'b1 || res_c00 !== e00 || res_c01 !== e01 ||
          res_c10 !== e10 || res_c11 !== e11) stable = 1'b0;
    end
    check({tag, ".held_stable"}, stable, 1);
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".res_valid_after"}, res_valid, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.op_ready", op_ready, 0);
    check("rst.res_valid", res_valid, 0);
    check("rst.res_c00", res_c00, 0);
    check("rst.mac_clear_all", mac_clear_all, 0);
    check("rst.mac_enable", mac_enable, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic multiply, no stalls
    load_basic();
    run_job("basic", 2, 2, 0, 0, 1'b0, 19, 22, 43, 50, 4, 2);

    // Reset asserted mid-FEED of a K=4 job
    fill_const(8'd9);
    start = 1'b1; k_len = KW'(4); set_beat(0); op_valid = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midrst.in_feed", op_ready, 1);
    reset = 1'b0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.op_ready", op_ready, 0);
    check("midrst.mac_enable", mac_enable, 0);
    check("midrst.mac_a_00", mac_a_00, 0);
    check("midrst.mac_b_11", mac_b_11, 0);
    check("midrst.res_valid", res_valid, 0);
    check("midrst.res_c11", res_c11, 0);
    check("midrst.done", done, 0);
    op_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    load_basic();
    run_job("post_rst", 2, 2, 0, 0, 1'b0, 19, 22, 43, 50, 4, 2);

    // Stalls on both sides
    run_job("stall", 2, 2, 3, 5, 1'b0, 19, 22, 43, 50, -1, 2);

    // Back-to-back jobs; second start lands in the done cycle
    ba0[0] = 10; ba1[0] = 12; bb0[0] = 10; bb1[0] = 12;
    run_job("b2b_1", 1, 1, 0, 0, 1'b0, 100, 120, 120, 144, 3, 1);
    ba0[0] = 11; ba1[0] = 13; bb0[0] = 11; bb1[0] = 13;
    run_job("b2b_2", 1, 1, 0, 0, 1'b0, 121, 143, 143, 169, 3, 1);

    // Maximum operands at maximum depth
    fill_const(8'd255);
    run_job("max", 16, 16, 0, 0, 1'b0, 1040400, 1040400, 1040400, 1040400, 18, 16);

    // K = 0
    run_job("k0", 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 2, 0);

    // start pulsed while busy
    load_basic();
    run_job("busy_start", 2, 2, 1, 0, 1'b1, 19, 22, 43, 50, -1, 2);
    check("busy_start.idle", busy, 0);

    // k_len above MAX_K clamps to 16 beats
    fill_const(8'd1);
    run_job("clamp", 20, 20, 0, 0, 1'b0, 16, 16, 16, 16, 18, 16);

    check("never_enable_and_clear", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
